// File: rtl/fmu_seq_ctrl.sv
// Sequencer for the pipelined FP32 multiplier datapath: accepts one operand pair,
// steps the datapath enables through a fixed schedule and returns the gated result.
//
// state  | meaning
// S_IDLE | waiting for an operand pair; start_ready high
// S_EXP  | register1 captures exponent sum / negated bias
// S_REG2 | register2 captures eo, mo
// S_MAN  | mantissa multiply; overflow collected
// S_OUT  | output stage; overflow collected
// S_REG4 | register3 captures result and flag; overflow collected
// S_DONE | waiting for result_in, bounded by DONE_TIMEOUT cycles
// S_HOLD | result presented on res_*; waiting for res_ready
module fmu_seq_ctrl #(
   parameter logic [7:0] BIAS         = 8'd127,
   parameter int         DONE_TIMEOUT = 8,
   parameter int         CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [31:0]      a_in,
   input  logic [31:0]      b_in,
   output logic [31:0]      a_op,
   output logic [31:0]      b_op,
   output logic [7:0]       bias_op,
   output logic             en_xor,
   output logic             neg1,
   output logic             reg2,
   output logic             man3,
   output logic             out4,
   output logic             reg4,
   output logic             done5,
   output logic             flag,
   input  logic             result_in,
   input  logic [31:0]      fpu_out,
   input  logic             overflow_in,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_data,
   output logic             res_ovf,
   output logic             res_err,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   localparam int TMO_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DONE_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXP,
      S_REG2,
      S_MAN,
      S_OUT,
      S_REG4,
      S_DONE,
      S_HOLD
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      a_op_q, a_op_d;
   logic [31:0]      b_op_q, b_op_d;
   logic [31:0]      res_data_q, res_data_d;
   logic             res_ovf_q, res_ovf_d;
   logic             res_err_q, res_err_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         a_op_q     <= '0;
         b_op_q     <= '0;
         res_data_q <= '0;
         res_ovf_q  <= 1'b0;
         res_err_q  <= 1'b0;
         tmo_q      <= '0;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         a_op_q     <= a_op_d;
         b_op_q     <= b_op_d;
         res_data_q <= res_data_d;
         res_ovf_q  <= res_ovf_d;
         res_err_q  <= res_err_d;
         tmo_q      <= tmo_d;
         op_count_q <= op_count_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      a_op_d      = a_op_q;
      b_op_d      = b_op_q;
      res_data_d  = res_data_q;
      res_ovf_d   = res_ovf_q;
      res_err_d   = res_err_q;
      tmo_d       = tmo_q;
      op_count_d  = op_count_q;
      start_ready = 1'b0;
      res_valid   = 1'b0;
      en_xor      = 1'b0;
      neg1        = 1'b0;
      reg2        = 1'b0;
      man3        = 1'b0;
      out4        = 1'b0;
      reg4        = 1'b0;
      done5       = 1'b0;
      flag        = 1'b0;

      case (state_q)
         S_IDLE: begin
            start_ready = 1'b1;
            if (start_valid) begin
               a_op_d    = a_in;
               b_op_d    = b_in;
               res_ovf_d = 1'b0;
               res_err_d = 1'b0;
               state_d   = S_EXP;
            end
         end
         S_EXP: begin
            en_xor  = 1'b1;
            neg1    = 1'b1;
            state_d = S_REG2;
         end
         S_REG2: begin
            en_xor  = 1'b1;
            neg1    = 1'b1;
            reg2    = 1'b1;
            state_d = S_MAN;
         end
         S_MAN: begin
            en_xor    = 1'b1;
            man3      = 1'b1;
            res_ovf_d = res_ovf_q | overflow_in;
            state_d   = S_OUT;
         end
         S_OUT: begin
            en_xor    = 1'b1;
            man3      = 1'b1;
            out4      = 1'b1;
            res_ovf_d = res_ovf_q | overflow_in;
            state_d   = S_REG4;
         end
         S_REG4: begin
            en_xor    = 1'b1;
            man3      = 1'b1;
            out4      = 1'b1;
            reg4      = 1'b1;
            res_ovf_d = res_ovf_q | overflow_in;
            tmo_d     = '0;
            state_d   = S_DONE;
         end
         S_DONE: begin
            done5 = 1'b1;
            flag  = 1'b1;
            // result_in wins even on the last allowed cycle
            if (result_in) begin
               res_data_d = fpu_out;
               state_d    = S_HOLD;
            end else if (tmo_q == TMO_LAST) begin
               res_data_d = '0;
               res_err_d  = 1'b1;
               state_d    = S_HOLD;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_HOLD: begin
            res_valid = 1'b1;
            if (res_ready) begin
               op_count_d = op_count_q + 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign a_op     = a_op_q;
   assign b_op     = b_op_q;
   assign bias_op  = BIAS;
   assign res_data = res_data_q;
   assign res_ovf  = res_ovf_q;
   assign res_err  = res_err_q;
   assign busy     = (state_q != S_IDLE);
   assign op_count = op_count_q;

endmodule

// File: tb/tb_fmu_seq_ctrl.sv
// Randomized bench for fmu_seq_ctrl; expected behaviour comes from a cycle-offset
// schedule model of one multiply (accept, 5 fixed steps, bounded wait, hold).
module tb_fmu_seq_ctrl;

   localparam int TMO = 8;
   localparam int CW  = 4;

   logic          clk = 1'b0;
   logic          rst, start_valid, start_ready;
   logic [31:0]   a_in, b_in, a_op, b_op, fpu_out, res_data;
   logic [7:0]    bias_op;
   logic          en_xor, neg1, reg2, man3, out4, reg4, done5, flag;
   logic          result_in, overflow_in, res_valid, res_ready, res_ovf, res_err, busy;
   logic [CW-1:0] op_count;
   logic [7:0]    en_now;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  trace [0:63];
   int          lat;
   logic [31:0] o_data;
   logic        o_ovf, o_err, o_aop_ok, o_hold_ok;
   int          exp_cnt;

   always #5 clk = ~clk;

   assign en_now = {en_xor, neg1, reg2, man3, out4, reg4, done5, flag};

   fmu_seq_ctrl #(.BIAS(8'd127), .DONE_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
      .a_in(a_in), .b_in(b_in), .a_op(a_op), .b_op(b_op), .bias_op(bias_op),
      .en_xor(en_xor), .neg1(neg1), .reg2(reg2), .man3(man3), .out4(out4),
      .reg4(reg4), .done5(done5), .flag(flag), .result_in(result_in),
      .fpu_out(fpu_out), .overflow_in(overflow_in), .res_valid(res_valid),
      .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf),
      .res_err(res_err), .busy(busy), .op_count(op_count)
   );

   // Expected enable vector {en_xor,neg1,reg2,man3,out4,reg4,done5,flag} at a
   // given number of cycles after the accept edge.
   function automatic logic [7:0] m_en(input int off, input int n_done);
      case (off)
         1: m_en = 8'b1100_0000;
         2: m_en = 8'b1110_0000;
         3: m_en = 8'b1001_0000;
         4: m_en = 8'b1001_1000;
         5: m_en = 8'b1001_1100;
         default: m_en = (off >= 6 && off < 6 + n_done) ? 8'b0000_0011 : 8'b0000_0000;
      endcase
   endfunction

   function automatic int m_done(input int rdelay);
      m_done = (rdelay < TMO) ? rdelay + 1 : TMO;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete multiply; records what the DUT showed for the test tasks to judge.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] fpu,
                         input int rdelay, input logic [7:0] ovf_at, input int rdy_wait);
      int cyc;
      logic [CW-1:0] pc;
      a_in = a; b_in = b; start_valid = 1'b1; res_ready = 1'b0;
      tick();
      start_valid = 1'b0; a_in = $urandom; b_in = $urandom;
      o_aop_ok = (a_op === a) && (b_op === b);
      cyc = 1; lat = -1;
      while (lat < 0 && cyc < 40) begin
         trace[cyc] = en_now;
         if (res_valid === 1'b1) begin
            lat = cyc;
         end else begin
            overflow_in = (cyc < 8) ? ovf_at[cyc[2:0]] : 1'b0;
            result_in   = (cyc == 6 + rdelay);
            fpu_out     = result_in ? fpu : $urandom;
            tick();
            cyc++;
         end
      end
      overflow_in = 1'b0; result_in = 1'b0;
      o_data = res_data; o_ovf = res_ovf; o_err = res_err; o_hold_ok = 1'b1;
      pc = op_count;
      for (int i = 0; i < rdy_wait; i++) begin
         start_valid = 1'b1; a_in = $urandom; b_in = $urandom; res_ready = 1'b0;
         tick();
         if (!(res_valid === 1'b1 && res_data === o_data && res_ovf === o_ovf &&
               res_err === o_err && start_ready === 1'b0 && busy === 1'b1 &&
               a_op === a && b_op === b && op_count === pc))
            o_hold_ok = 1'b0;
      end
      start_valid = 1'b0; res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      exp_cnt = (exp_cnt + 1) % (1 << CW);
   endtask

   task automatic test_reset();
      rst = 1'b1; start_valid = 1'b1; a_in = 32'hDEAD_BEEF; b_in = 32'h1234_5678;
      tick();
      tick();
      exp_cnt = 0;
      n_cmp++; if (en_now !== 8'h00) begin n_bad++; $display("FAIL rst_enables got=%h exp=00", en_now); end
      n_cmp++; if (start_ready !== 1'b1) begin n_bad++; $display("FAIL rst_start_ready got=%b exp=1", start_ready); end
      n_cmp++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_bad++; $display("FAIL rst_busy_valid got=%b%b exp=00", busy, res_valid); end
      n_cmp++; if (a_op !== 32'h0 || b_op !== 32'h0) begin n_bad++; $display("FAIL rst_ops got=%h/%h exp=0/0", a_op, b_op); end
      n_cmp++; if (res_data !== 32'h0 || res_ovf !== 1'b0 || res_err !== 1'b0) begin n_bad++; $display("FAIL rst_res got=%h %b %b exp=0 0 0", res_data, res_ovf, res_err); end
      n_cmp++; if (op_count !== '0) begin n_bad++; $display("FAIL rst_op_count got=%0d exp=0", op_count); end
      n_cmp++; if (bias_op !== 8'd127) begin n_bad++; $display("FAIL rst_bias got=%0d exp=127", bias_op); end
      rst = 1'b0; start_valid = 1'b0;
      tick();
      n_cmp++; if (start_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL idle_after_rst got=%b%b exp=10", start_ready, busy); end
   endtask

   task automatic test_basic();
      run_op(32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 0, 8'h00, 0);
      n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL basic_latency got=%0d exp=7", lat); end
      n_cmp++; if (o_data !== 32'h4000_0000) begin n_bad++; $display("FAIL basic_data got=%h exp=40000000", o_data); end
      n_cmp++; if (o_ovf !== 1'b0 || o_err !== 1'b0) begin n_bad++; $display("FAIL basic_flags got=%b%b exp=00", o_ovf, o_err); end
      n_cmp++; if (o_aop_ok !== 1'b1) begin n_bad++; $display("FAIL basic_operands got=%h/%h exp=3f800000/40000000", a_op, b_op); end
      for (int off = 1; off <= 7; off++) begin
         n_cmp++;
         if (trace[off] !== m_en(off, 1)) begin
            n_bad++; $display("FAIL basic_enables off=%0d got=%b exp=%b", off, trace[off], m_en(off, 1));
         end
      end
      n_cmp++; if (op_count !== exp_cnt[CW-1:0]) begin n_bad++; $display("FAIL basic_op_count got=%0d exp=%0d", op_count, exp_cnt); end
   endtask

   task automatic test_overflow();
      run_op(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 0, 8'b0001_0000, 0);
      n_cmp++; if (o_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_in_out_stage got=%b exp=1", o_ovf); end
      run_op(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 0, 8'b0100_0110, 0);
      n_cmp++; if (o_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_cleared_outside_window got=%b exp=0", o_ovf); end
   endtask

   task automatic test_timeout();
      int nd;
      run_op(32'h4040_0000, 32'h4080_0000, 32'h4140_0000, 100, 8'h00, 0);
      nd = 0;
      for (int off = 6; off < 40; off++) if (off < lat && trace[off] === 8'b0000_0011) nd++;
      n_cmp++; if (lat !== 6 + TMO) begin n_bad++; $display("FAIL tmo_latency got=%0d exp=%0d", lat, 6 + TMO); end
      n_cmp++; if (nd !== TMO) begin n_bad++; $display("FAIL tmo_done_cycles got=%0d exp=%0d", nd, TMO); end
      n_cmp++; if (o_data !== 32'h0 || o_err !== 1'b1) begin n_bad++; $display("FAIL tmo_result got=%h err=%b exp=0 err=1", o_data, o_err); end
      run_op(32'h4040_0000, 32'h4080_0000, 32'h4140_0000, TMO - 1, 8'h00, 0);
      n_cmp++; if (o_data !== 32'h4140_0000 || o_err !== 1'b0 || lat !== 6 + TMO) begin
         n_bad++; $display("FAIL tmo_last_cycle_result got=%h err=%b lat=%0d exp=41400000 err=0 lat=%0d", o_data, o_err, lat, 6 + TMO);
      end
   endtask

   task automatic test_hold();
      run_op(32'hC000_0000, 32'h4000_0000, 32'hC080_0000, 2, 8'h00, 5);
      n_cmp++; if (o_hold_ok !== 1'b1) begin n_bad++; $display("FAIL hold_stable got=%b exp=1", o_hold_ok); end
      n_cmp++; if (o_data !== 32'hC080_0000) begin n_bad++; $display("FAIL hold_data got=%h exp=c0800000", o_data); end
      n_cmp++; if (op_count !== exp_cnt[CW-1:0]) begin n_bad++; $display("FAIL hold_op_count got=%0d exp=%0d", op_count, exp_cnt); end
      n_cmp++; if (start_ready !== 1'b1) begin n_bad++; $display("FAIL hold_back_to_idle got=%b exp=1", start_ready); end
   endtask

   task automatic test_reset_mid();
      a_in = 32'h1111_1111; b_in = 32'h2222_2222; start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      tick();
      tick();
      n_cmp++; if (man3 !== 1'b1 || reg2 !== 1'b0) begin n_bad++; $display("FAIL midrst_in_man got=%b exp=10010000", en_now); end
      rst = 1'b1;
      tick();
      rst = 1'b0; exp_cnt = 0;
      n_cmp++; if (en_now !== 8'h00 || res_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_enables got=%b valid=%b exp=0", en_now, res_valid); end
      n_cmp++; if (busy !== 1'b0 || start_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_idle got=%b%b exp=01", busy, start_ready); end
      n_cmp++; if (op_count !== '0 || a_op !== 32'h0) begin n_bad++; $display("FAIL midrst_regs got=%0d %h exp=0 0", op_count, a_op); end
   endtask

   task automatic test_back_to_back();
      int acc[$];
      logic [31:0] vals[3];
      logic [31:0] got[$];
      for (int i = 0; i < 3; i++) vals[i] = $urandom;
      start_valid = 1'b1; res_ready = 1'b1; result_in = 1'b1;
      for (int c = 0; c < 24; c++) begin
         if (start_ready === 1'b1 && acc.size() < 3) begin
            fpu_out = vals[acc.size()];
            acc.push_back(c);
            a_in = $urandom;
         end
         if (res_valid === 1'b1) got.push_back(res_data);
         tick();
      end
      start_valid = 1'b0; res_ready = 1'b0; result_in = 1'b0;
      exp_cnt = (exp_cnt + 3) % (1 << CW);
      n_cmp++; if (acc.size() !== 3 || got.size() !== 3) begin n_bad++; $display("FAIL b2b_counts got=%0d/%0d exp=3/3", acc.size(), got.size()); end
      else begin
         n_cmp++; if (acc[1] - acc[0] !== 8 || acc[2] - acc[1] !== 8) begin n_bad++; $display("FAIL b2b_spacing got=%0d,%0d exp=8,8", acc[1] - acc[0], acc[2] - acc[1]); end
         for (int i = 0; i < 3; i++) begin
            n_cmp++; if (got[i] !== vals[i]) begin n_bad++; $display("FAIL b2b_data i=%0d got=%h exp=%h", i, got[i], vals[i]); end
         end
      end
      n_cmp++; if (op_count !== exp_cnt[CW-1:0]) begin n_bad++; $display("FAIL b2b_op_count got=%0d exp=%0d", op_count, exp_cnt); end
      n_cmp++; if (start_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle got=%b exp=1", start_ready); end
   endtask

   task automatic test_random();
      logic [31:0] a, b, f, e_data;
      logic [7:0]  ov;
      int          rd, rw, nd;
      for (int n = 0; n < 20; n++) begin
         a = $urandom; b = $urandom; f = $urandom; ov = 8'($urandom);
         rd = $urandom_range(0, 10); rw = $urandom_range(0, 3);
         run_op(a, b, f, rd, ov, rw);
         nd = m_done(rd);
         e_data = (rd < TMO) ? f : 32'h0;
         n_cmp++; if (lat !== 6 + nd) begin n_bad++; $display("FAIL rnd_latency n=%0d got=%0d exp=%0d", n, lat, 6 + nd); end
         n_cmp++; if (o_data !== e_data) begin n_bad++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, o_data, e_data); end
         n_cmp++; if (o_err !== (rd >= TMO)) begin n_bad++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, o_err, rd >= TMO); end
         n_cmp++; if (o_ovf !== (|ov[5:3])) begin n_bad++; $display("FAIL rnd_ovf n=%0d got=%b exp=%b", n, o_ovf, |ov[5:3]); end
         n_cmp++; if (o_aop_ok !== 1'b1 || o_hold_ok !== 1'b1) begin n_bad++; $display("FAIL rnd_stable n=%0d got=%b%b exp=11", n, o_aop_ok, o_hold_ok); end
         for (int off = 1; off <= 6 + nd && off < 40; off++) begin
            n_cmp++;
            if (trace[off] !== m_en(off, nd)) begin
               n_bad++; $display("FAIL rnd_enables n=%0d off=%0d got=%b exp=%b", n, off, trace[off], m_en(off, nd));
            end
         end
         n_cmp++; if (op_count !== exp_cnt[CW-1:0]) begin n_bad++; $display("FAIL rnd_op_count n=%0d got=%0d exp=%0d", n, op_count, exp_cnt); end
      end
   endtask

   initial begin
      rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0; result_in = 1'b0;
      overflow_in = 1'b0; a_in = '0; b_in = '0; fpu_out = '0; exp_cnt = 0;
      test_reset();
      test_basic();
      test_overflow();
      test_timeout();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
